// File: rtl/rf_pkg.sv
// Shared types and default widths for the register-file write-port arbiter.
package rf_pkg;

    localparam int RF_DATA_W   = 16;
    localparam int RF_ADDR_W   = 4;
    localparam int RF_MAX_WAIT = 4;

    typedef enum logic [0:0] {
        PRIO_WB  = 1'b0,
        PRIO_AUX = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] dst;
        logic [RF_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rf_starve_ctr.sv
// Saturating AUX starvation counter; flags when the upcoming count reaches the promotion threshold.
module rf_starve_ctr #(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] cnt,
    output logic       at_max
);

    localparam logic [3:0] MAX_L = 4'(MAX_WAIT);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Next count: clear on AUX transfer, otherwise count stalls up to the threshold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (inc && (cnt_q != MAX_L)) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Promotion is decided on the value being loaded, so AUX wins on the cycle after its last stall.
    assign at_max = (cnt_d == MAX_L);
    assign cnt    = cnt_q;

endmodule

// File: rtl/rf_wport_arbiter.sv
// Arbitrates the register file's single write port between WB and AUX,
// with WB priority, AUX anti-starvation promotion and a registered write stage.
module rf_wport_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int MAX_WAIT = RF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_ready,
    input  logic              aux_valid,
    input  logic [ADDR_W-1:0] aux_dst,
    input  logic [DATA_W-1:0] aux_data,
    output logic              aux_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_dst,
    output logic [DATA_W-1:0] rf_data,
    output logic              aux_promoted
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              rf_we_q;
    logic              rf_we_d;
    logic [ADDR_W-1:0] rf_dst_q;
    logic [ADDR_W-1:0] rf_dst_d;
    logic [DATA_W-1:0] rf_data_q;
    logic [DATA_W-1:0] rf_data_d;

    logic              wb_xfer_s;
    logic              aux_xfer_s;
    logic              aux_stall_s;
    logic              promote_s;
    logic [3:0]        starve_cnt_s;

    // Grant decode from the current priority state; nothing is granted during reset.
    always_comb begin
        wb_ready  = 1'b0;
        aux_ready = 1'b0;
        if (rst) begin
            wb_ready  = 1'b0;
            aux_ready = 1'b0;
        end else begin
            case (state_q)
                PRIO_WB: begin
                    wb_ready  = wb_valid;
                    aux_ready = aux_valid && !wb_valid;
                end
                PRIO_AUX: begin
                    aux_ready = aux_valid;
                    wb_ready  = wb_valid && !aux_valid;
                end
                default: begin
                    wb_ready  = 1'b0;
                    aux_ready = 1'b0;
                end
            endcase
        end
    end

    assign wb_xfer_s   = wb_valid && wb_ready;
    assign aux_xfer_s  = aux_valid && aux_ready;
    assign aux_stall_s = aux_valid && !aux_ready;

    rf_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (aux_stall_s),
        .clr    (aux_xfer_s),
        .cnt    (starve_cnt_s),
        .at_max (promote_s)
    );

    // Priority state: promote a starved AUX, drop back once AUX has been served.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PRIO_WB: begin
                if (promote_s) begin
                    state_d = PRIO_AUX;
                end else begin
                    state_d = PRIO_WB;
                end
            end
            PRIO_AUX: begin
                if (aux_xfer_s) begin
                    state_d = PRIO_WB;
                end else begin
                    state_d = PRIO_AUX;
                end
            end
            default: state_d = PRIO_WB;
        endcase
    end

    // Write stage: capture the winner; r0 is hardwired zero so its writes never assert rf_we.
    always_comb begin
        rf_we_d   = 1'b0;
        rf_dst_d  = rf_dst_q;
        rf_data_d = rf_data_q;
        if (wb_xfer_s) begin
            rf_we_d   = (wb_dst != {ADDR_W{1'b0}});
            rf_dst_d  = wb_dst;
            rf_data_d = wb_data;
        end else if (aux_xfer_s) begin
            rf_we_d   = (aux_dst != {ADDR_W{1'b0}});
            rf_dst_d  = aux_dst;
            rf_data_d = aux_data;
        end else begin
            rf_we_d   = 1'b0;
            rf_dst_d  = rf_dst_q;
            rf_data_d = rf_data_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= PRIO_WB;
            rf_we_q   <= 1'b0;
            rf_dst_q  <= {ADDR_W{1'b0}};
            rf_data_q <= {DATA_W{1'b0}};
        end else begin
            state_q   <= state_d;
            rf_we_q   <= rf_we_d;
            rf_dst_q  <= rf_dst_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_dst       = rf_dst_q;
    assign rf_data      = rf_data_q;
    assign aux_promoted = (state_q == PRIO_AUX);

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed self-checking bench for rf_wport_arbiter (default parameters, MAX_WAIT = 4).
module tb_rf_wport_arbiter;
    import rf_pkg::*;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [3:0]  wb_dst;
    logic [15:0] wb_data;
    logic        wb_ready;
    logic        aux_valid;
    logic [3:0]  aux_dst;
    logic [15:0] aux_data;
    logic        aux_ready;
    logic        rf_we;
    logic [3:0]  rf_dst;
    logic [15:0] rf_data;
    logic        aux_promoted;

    int errors;
    int checks;

    rf_wport_arbiter #(
        .DATA_W   (16),
        .ADDR_W   (4),
        .MAX_WAIT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_valid     (wb_valid),
        .wb_dst       (wb_dst),
        .wb_data      (wb_data),
        .wb_ready     (wb_ready),
        .aux_valid    (aux_valid),
        .aux_dst      (aux_dst),
        .aux_data     (aux_data),
        .aux_ready    (aux_ready),
        .rf_we        (rf_we),
        .rf_dst       (rf_dst),
        .rf_data      (rf_data),
        .aux_promoted (aux_promoted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid  = 1'b0;
        aux_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        wb_valid = 1'b1;
        wb_dst   = 4'd3;
        wb_data  = 16'h1111;
        aux_valid = 1'b1;
        aux_dst  = 4'd5;
        aux_data = 16'h2222;
        #1;
        checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL reset_wb_ready got=%b want=0", wb_ready); end
        checks++; if (aux_ready !== 1'b0) begin errors++; $display("FAIL reset_aux_ready got=%b want=0", aux_ready); end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got=%b want=0", rf_we); end
        checks++; if (rf_dst !== 4'd0 || rf_data !== 16'h0000) begin errors++; $display("FAIL reset_rf_payload got=%h/%h want=0/0000", rf_dst, rf_data); end
        checks++; if (aux_promoted !== 1'b0) begin errors++; $display("FAIL reset_promoted got=%b want=0", aux_promoted); end
        idle();
        rst = 1'b0;
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_release_rf_we got=%b want=0", rf_we); end
    endtask

    task automatic test_wb_only();
        wb_valid = 1'b1;
        wb_dst   = 4'd3;
        wb_data  = 16'hBEEF;
        #1;
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL wbonly_ready got=%b want=1", wb_ready); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL wbonly_pre_we got=%b want=0", rf_we); end
        tick();
        wb_valid = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_dst !== 4'd3 || rf_data !== 16'hBEEF) begin
            errors++; $display("FAIL wbonly_write got=%b/%h/%h want=1/3/beef", rf_we, rf_dst, rf_data); end
        tick();
        checks++; if (rf_we !== 1'b0 || rf_dst !== 4'd3 || rf_data !== 16'hBEEF) begin
            errors++; $display("FAIL wbonly_hold got=%b/%h/%h want=0/3/beef", rf_we, rf_dst, rf_data); end
    endtask

    // WB streams every cycle; AUX holds r7=0x00FF and must win after exactly 4 stalls, twice.
    task automatic test_contention();
        int stalls;
        int r7_writes;
        bit granted;
        for (int round = 0; round < 2; round++) begin
            stalls    = 0;
            r7_writes = 0;
            granted   = 1'b0;
            aux_valid = 1'b1;
            aux_dst   = 4'd7;
            aux_data  = 16'h00FF;
            for (int c = 0; c < 20 && !granted; c++) begin
                wb_valid = 1'b1;
                wb_dst   = 4'(c % 5 + 1);
                wb_data  = 16'hA000 + 16'(c);
                #1;
                if (aux_ready === 1'b1) begin
                    granted = 1'b1;
                    checks++; if (wb_ready !== 1'b0 || aux_promoted !== 1'b1) begin
                        errors++; $display("FAIL contend_grant r%0d wb_ready=%b promoted=%b want 0/1", round, wb_ready, aux_promoted); end
                    tick();
                    aux_valid = 1'b0;
                    checks++; if (rf_we !== 1'b1 || rf_dst !== 4'd7 || rf_data !== 16'h00FF) begin
                        errors++; $display("FAIL contend_aux_write r%0d got=%b/%h/%h want=1/7/00ff", round, rf_we, rf_dst, rf_data); end
                    if (rf_we === 1'b1 && rf_dst === 4'd7) r7_writes++;
                    checks++; if (aux_promoted !== 1'b0) begin
                        errors++; $display("FAIL contend_demote r%0d got=%b want=0", round, aux_promoted); end
                end else begin
                    stalls++;
                    tick();
                    checks++; if (rf_we !== 1'b1 || rf_dst !== 4'(c % 5 + 1) || rf_data !== 16'hA000 + 16'(c)) begin
                        errors++; $display("FAIL contend_wb_write r%0d c%0d got=%b/%h/%h", round, c, rf_we, rf_dst, rf_data); end
                end
            end
            checks++; if (!granted || stalls != 4) begin
                errors++; $display("FAIL contend_stalls r%0d granted=%b stalls=%0d want 1/4", round, granted, stalls); end
            // Two more WB cycles: AUX gone, no duplicate r7 write.
            for (int c = 0; c < 2; c++) begin
                wb_dst  = 4'd2;
                wb_data = 16'hC000 + 16'(c);
                #1;
                checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL contend_after_ready r%0d got=%b want=1", round, wb_ready); end
                tick();
                if (rf_we === 1'b1 && rf_dst === 4'd7) r7_writes++;
            end
            checks++; if (r7_writes != 1) begin errors++; $display("FAIL contend_r7_count r%0d got=%0d want=1", round, r7_writes); end
        end
        idle();
        tick();
    endtask

    task automatic test_r0_discard();
        aux_valid = 1'b1;
        aux_dst   = 4'd0;
        aux_data  = 16'h1234;
        #1;
        checks++; if (aux_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got=%b want=1", aux_ready); end
        tick();
        aux_valid = 1'b0;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL r0_we got=%b want=0", rf_we); end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL r0_we_after got=%b want=0", rf_we); end
    endtask

    task automatic test_back_to_back();
        wr_req_t vec [5];
        for (int i = 0; i < 5; i++) begin
            vec[i].dst  = 4'(i + 1);
            vec[i].data = 16'h0100 * 16'(i + 1) + 16'h0055;
        end
        for (int i = 0; i < 5; i++) begin
            wb_valid = 1'b1;
            wb_dst   = vec[i].dst;
            wb_data  = vec[i].data;
            tick();
            checks++; if (rf_we !== 1'b1 || rf_dst !== vec[i].dst || rf_data !== vec[i].data) begin
                errors++; $display("FAIL b2b_%0d got=%b/%h/%h want=1/%h/%h", i, rf_we, rf_dst, rf_data, vec[i].dst, vec[i].data); end
        end
        wb_valid = 1'b0;
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL b2b_end_we got=%b want=0", rf_we); end
    endtask

    task automatic test_mid_reset();
        // Build up a promotion, then transfer, then reset with the write pending.
        wb_valid  = 1'b1;
        wb_dst    = 4'd9;
        wb_data   = 16'h5A5A;
        aux_valid = 1'b1;
        aux_dst   = 4'd6;
        aux_data  = 16'h0F0F;
        for (int c = 0; c < 4; c++) tick();
        checks++; if (aux_promoted !== 1'b1) begin errors++; $display("FAIL midrst_promoted got=%b want=1", aux_promoted); end
        aux_valid = 1'b0;
        tick();
        checks++; if (rf_we !== 1'b1 || rf_dst !== 4'd9) begin errors++; $display("FAIL midrst_pre got=%b/%h want=1/9", rf_we, rf_dst); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (rf_we !== 1'b0 || rf_dst !== 4'd0 || rf_data !== 16'h0000) begin
            errors++; $display("FAIL midrst_async got=%b/%h/%h want=0/0/0000", rf_we, rf_dst, rf_data); end
        checks++; if (wb_ready !== 1'b0 || aux_promoted !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl wb_ready=%b promoted=%b want 0/0", wb_ready, aux_promoted); end
        tick();
        rst = 1'b0;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL midrst_held got=%b want=0", rf_we); end
        tick();
        wb_valid = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_dst !== 4'd9 || rf_data !== 16'h5A5A) begin
            errors++; $display("FAIL midrst_resume got=%b/%h/%h want=1/9/5a5a", rf_we, rf_dst, rf_data); end
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        wb_valid = 1'b0; wb_dst = 4'd0; wb_data = 16'h0000;
        aux_valid = 1'b0; aux_dst = 4'd0; aux_data = 16'h0000;
        test_reset();
        test_wb_only();
        test_contention();
        test_r0_discard();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
